spmv_row_sequencer: RTL and testbench

- Sequences one sparse matrix-vector pass over a CSR matrix already loaded into word memory by the byte-assembly control path.
- Reads the row-pointer array and the packed (column, value) entries through a single read port.
- Streams one MAC beat per nonzero to the multiply-accumulate datapath, marking row boundaries and empty rows.
- Sits between the matrix memory and the MAC/accumulator unit; it is started by the host-side controller once loading completes.

---
 rtl/spmv_row_sequencer.sv | 173 +++++++++++++++++
 tb/tb_spmv_row_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_row_sequencer.sv
// Walks a CSR matrix (row_ptr + packed col/val entries) through one read port and
// emits one MAC beat per nonzero, plus a single empty-marker beat for each empty row.
module spmv_row_sequencer #(
  parameter int ADDR_W = 32,
  parameter int ROW_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic [ADDR_W-1:0] ptr_base,
  input  logic [ADDR_W-1:0] ent_base,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_valid,
  input  logic [63:0]       rd_data,
  output logic              mac_valid,
  input  logic              mac_ready,
  output logic [31:0]       mac_col,
  output logic [31:0]       mac_val,
  output logic [ROW_W-1:0]  mac_row,
  output logic              mac_last,
  output logic              mac_empty,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, RD_P0, RD_PN, RD_E, ISSUE, EMPTY, NEXT, FIN} state_t;

  state_t            state;
  logic [ROW_W-1:0]  rows, r;
  logic [ADDR_W-1:0] pbase, ebase;
  logic [31:0]       cur, nxt, k;
  logic [ROW_W-1:0]  r_inc;
  logic [31:0]       k_inc;
  logic              ret;

  assign r_inc = r + ROW_W'(1);
  assign k_inc = k + 32'd1;
  // Every read state is entered with rd_req high, so rd_req low there means
  // the request was granted and its data is outstanding.
  assign ret = rd_valid && !rd_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rows      <= '0;
      r         <= '0;
      pbase     <= '0;
      ebase     <= '0;
      cur       <= '0;
      nxt       <= '0;
      k         <= '0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      mac_valid <= 1'b0;
      mac_col   <= '0;
      mac_val   <= '0;
      mac_row   <= '0;
      mac_last  <= 1'b0;
      mac_empty <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (rd_req && rd_gnt) rd_req <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            rows  <= num_rows;
            pbase <= ptr_base;
            ebase <= ent_base;
            err   <= 1'b0;
            busy  <= 1'b1;
            r     <= '0;
            if (num_rows == '0) begin
              state <= FIN;
            end else begin
              rd_req  <= 1'b1;
              rd_addr <= ptr_base;
              state   <= RD_P0;
            end
          end
        end
        RD_P0: begin
          if (ret) begin
            cur     <= rd_data[31:0];
            rd_req  <= 1'b1;
            rd_addr <= pbase + ADDR_W'(r_inc);
            state   <= RD_PN;
          end
        end
        RD_PN: begin
          if (ret) begin
            nxt <= rd_data[31:0];
            if (rd_data[31:0] < cur) begin
              err   <= 1'b1;
              state <= FIN;
            end else if (rd_data[31:0] == cur) begin
              mac_valid <= 1'b1;
              mac_empty <= 1'b1;
              mac_last  <= 1'b1;
              mac_col   <= '0;
              mac_val   <= '0;
              mac_row   <= r;
              state     <= EMPTY;
            end else begin
              k       <= cur;
              rd_req  <= 1'b1;
              rd_addr <= ebase + ADDR_W'(cur);
              state   <= RD_E;
            end
          end
        end
        RD_E: begin
          if (ret) begin
            mac_valid <= 1'b1;
            mac_empty <= 1'b0;
            mac_col   <= rd_data[63:32];
            mac_val   <= rd_data[31:0];
            mac_row   <= r;
            mac_last  <= (k_inc == nxt);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mac_ready) begin
            mac_valid <= 1'b0;
            mac_last  <= 1'b0;
            if (mac_last) begin
              state <= NEXT;
            end else begin
              k       <= k_inc;
              rd_req  <= 1'b1;
              rd_addr <= ebase + ADDR_W'(k_inc);
              state   <= RD_E;
            end
          end
        end
        EMPTY: begin
          if (mac_ready) begin
            mac_valid <= 1'b0;
            mac_last  <= 1'b0;
            mac_empty <= 1'b0;
            state     <= NEXT;
          end
        end
        NEXT: begin
          cur <= nxt;
          r   <= r_inc;
          if (r_inc == rows) begin
            state <= FIN;
          end else begin
            rd_req  <= 1'b1;
            rd_addr <= pbase + ADDR_W'(r_inc) + ADDR_W'(1);
            state   <= RD_PN;
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_row_sequencer.sv
// Directed bench for spmv_row_sequencer: table of CSR passes with expected beats,
// plus hand-written sequences for reset, stall, empty-matrix and late-data cases.
module tb_spmv_row_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_rows = '0;
  logic [31:0] ptr_base = '0;
  logic [31:0] ent_base = '0;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_gnt;
  logic        rd_valid = 1'b0;
  logic [63:0] rd_data = '0;
  logic        mac_valid;
  logic        mac_ready = 1'b1;
  logic [31:0] mac_col, mac_val;
  logic [15:0] mac_row;
  logic        mac_last, mac_empty, busy, done, err;

  spmv_row_sequencer #(.ADDR_W(32), .ROW_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
    .ptr_base(ptr_base), .ent_base(ent_base),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_col(mac_col),
    .mac_val(mac_val), .mac_row(mac_row), .mac_last(mac_last),
    .mac_empty(mac_empty), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Memory model: immediate grant, data after 'lat' cycles (lat=1 -> next cycle).
  logic [63:0] mem [64];
  int          lat = 1;
  int          cnt = 0;
  logic [5:0]  paddr = '0;
  assign rd_gnt = rd_req;

  always @(posedge clk) begin
    rd_valid <= 1'b0;
    if (cnt == 1) begin
      rd_valid <= 1'b1;
      rd_data  <= mem[paddr];
    end
    if (cnt > 0) cnt <= cnt - 1;
    if (rd_req && rd_gnt) begin
      paddr <= rd_addr[5:0];
      if (lat == 1) begin
        rd_valid <= 1'b1;
        rd_data  <= mem[rd_addr[5:0]];
      end else begin
        cnt <= lat - 1;
      end
    end
  end

  // Beat and grant monitor
  int          cyc = 0;
  int          nb = 0;
  int          ngnt = 0;
  logic [15:0] b_row [8];
  logic [31:0] b_col [8];
  logic [31:0] b_val [8];
  logic        b_last [8];
  logic        b_empty [8];
  int          b_cyc [8];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mac_valid && mac_ready) begin
      if (nb < 8) begin
        b_row[nb] = mac_row; b_col[nb] = mac_col; b_val[nb] = mac_val;
        b_last[nb] = mac_last; b_empty[nb] = mac_empty; b_cyc[nb] = cyc;
      end
      nb = nb + 1;
    end
    if (rd_req && rd_gnt) ngnt = ngnt + 1;
  end

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk(name, {rd_req, rd_addr, mac_valid, mac_col, mac_val, mac_row,
               mac_last, mac_empty, busy, done, err}, 128'd0);
  endtask

  typedef struct {
    int               nrows;
    logic [31:0]      pbase;
    logic [3:0][31:0] ptr;
    logic [2:0][63:0] ent;
    int               nb;
    int               ngnt;
    logic [2:0][15:0] erow;
    logic [2:0][31:0] ecol;
    logic [2:0][31:0] evl;
    logic [2:0]       elast;
    logic [2:0]       eempty;
    logic             eerr;
    logic             stall;
    logic             bstart;
  } vec_t;

  vec_t tv [4];

  task automatic load(input int i);
    for (int j = 0; j <= tv[i].nrows; j++)
      mem[6'(tv[i].pbase + 32'(j))] = {32'd0, tv[i].ptr[j]};
    for (int j = 0; j < 3; j++) mem[16 + j] = tv[i].ent[j];
  endtask

  task automatic pulse_start(input int n, input logic [31:0] pb, input logic [31:0] eb);
    @(posedge clk); #1;
    start = 1'b1; num_rows = 16'(n); ptr_base = pb; ent_base = eb;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input int i);
    int t;
    load(i);
    nb = 0; ngnt = 0;
    mac_ready = !tv[i].stall;
    pulse_start(tv[i].nrows, tv[i].pbase, 32'd16);
    if (tv[i].bstart) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1; num_rows = 16'd0;
      @(posedge clk); #1 start = 1'b0;
    end
    if (tv[i].stall) begin
      t = 0;
      @(negedge clk);
      while (!mac_valid && t < 100) begin @(negedge clk); t++; end
      for (int j = 0; j < 4; j++) begin
        chk("stall_valid", mac_valid, 1);
        chk("stall_col", mac_col, 1);
        chk("stall_val", mac_val, 10);
        @(negedge clk);
      end
      @(posedge clk); #1 mac_ready = 1'b1;
    end
    t = 0;
    @(negedge clk);
    while (!done && t < 300) begin @(negedge clk); t++; end
    chk($sformatf("v%0d_done_seen", i), done, 1);
    chk($sformatf("v%0d_busy_at_done", i), busy, 0);
    chk($sformatf("v%0d_err", i), err, tv[i].eerr);
    chk($sformatf("v%0d_beats", i), nb, tv[i].nb);
    chk($sformatf("v%0d_grants", i), ngnt, tv[i].ngnt);
    for (int j = 0; j < tv[i].nb && j < nb; j++) begin
      chk($sformatf("v%0d_b%0d_row", i, j), b_row[j], tv[i].erow[j]);
      chk($sformatf("v%0d_b%0d_col", i, j), b_col[j], tv[i].ecol[j]);
      chk($sformatf("v%0d_b%0d_val", i, j), b_val[j], tv[i].evl[j]);
      chk($sformatf("v%0d_b%0d_last", i, j), b_last[j], tv[i].elast[j]);
      chk($sformatf("v%0d_b%0d_empty", i, j), b_empty[j], tv[i].eempty[j]);
    end
    if (i == 0 && !tv[i].stall && nb >= 2)
      chk("beat_spacing", b_cyc[1] - b_cyc[0], 3);
    @(negedge clk);
    chk($sformatf("v%0d_done_pulse", i), done, 0);
    @(negedge clk);
    chk($sformatf("v%0d_err_sticky", i), err, tv[i].eerr);
  endtask

  initial begin
    int t;
    // v0: two rows, three nonzeros
    tv[0].nrows = 2; tv[0].pbase = 32'd0;
    tv[0].ptr = {32'd0, 32'd3, 32'd2, 32'd0};
    tv[0].ent = {{32'd0, 32'd30}, {32'd3, 32'd20}, {32'd1, 32'd10}};
    tv[0].nb = 3; tv[0].ngnt = 6;
    tv[0].erow = {16'd1, 16'd0, 16'd0};
    tv[0].ecol = {32'd0, 32'd3, 32'd1};
    tv[0].evl  = {32'd30, 32'd20, 32'd10};
    tv[0].elast = 3'b110; tv[0].eempty = 3'b000;
    tv[0].eerr = 1'b0; tv[0].stall = 1'b0; tv[0].bstart = 1'b0;
    // v1: empty first row, row_ptr wraps past top of address space, stray start mid-pass
    tv[1].nrows = 2; tv[1].pbase = 32'hFFFF_FFFE;
    tv[1].ptr = {32'd0, 32'd1, 32'd0, 32'd0};
    tv[1].ent = {64'd0, 64'd0, {32'd5, 32'd7}};
    tv[1].nb = 2; tv[1].ngnt = 4;
    tv[1].erow = {16'd0, 16'd1, 16'd0};
    tv[1].ecol = {32'd0, 32'd5, 32'd0};
    tv[1].evl  = {32'd0, 32'd7, 32'd0};
    tv[1].elast = 3'b011; tv[1].eempty = 3'b001;
    tv[1].eerr = 1'b0; tv[1].stall = 1'b0; tv[1].bstart = 1'b1;
    // v2: non-monotonic row_ptr
    tv[2].nrows = 1; tv[2].pbase = 32'd40;
    tv[2].ptr = {32'd0, 32'd0, 32'd1, 32'd3};
    tv[2].ent = {64'd0, 64'd0, 64'd0};
    tv[2].nb = 0; tv[2].ngnt = 2;
    tv[2].erow = '0; tv[2].ecol = '0; tv[2].evl = '0;
    tv[2].elast = '0; tv[2].eempty = '0;
    tv[2].eerr = 1'b1; tv[2].stall = 1'b0; tv[2].bstart = 1'b0;
    // v3: v0 with the first beat stalled
    tv[3] = tv[0];
    tv[3].stall = 1'b1;

    for (int j = 0; j < 64; j++) mem[j] = '0;

    repeat (3) @(negedge clk);
    chk_idle("reset_outputs");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_idle("after_reset");

    // start coincident with reset
    @(posedge clk); #1 reset = 1'b1; start = 1'b1; num_rows = 16'd2;
    @(posedge clk); #1 reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk_idle("start_with_reset");

    run_vec(0);
    run_vec(1);
    run_vec(2);
    run_vec(3);

    // Empty matrix: no reads, done two cycles after start
    ngnt = 0;
    pulse_start(0, 32'd0, 32'd16);
    @(negedge clk);
    chk("nr0_done_early", done, 0);
    chk("nr0_busy", busy, 1);
    @(negedge clk);
    chk("nr0_done", done, 1);
    chk("nr0_busy_clear", busy, 0);
    @(negedge clk);
    chk("nr0_done_pulse", done, 0);
    chk("nr0_grants", ngnt, 0);

    // Reset while a read is outstanding; its late data must be discarded
    load(0);
    lat = 5; nb = 0; mac_ready = 1'b1;
    pulse_start(2, 32'd0, 32'd16);
    t = 0;
    @(negedge clk);
    while (!(rd_req && rd_gnt) && t < 50) begin @(negedge clk); t++; end
    chk("midreset_grant_seen", rd_req, 1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    ngnt = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk_idle($sformatf("midreset_idle%0d", j));
    end
    chk("midreset_beats", nb, 0);
    chk("midreset_grants", ngnt, 0);
    lat = 1;
    run_vec(0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
